// File: rtl/ahb_push_buffer.sv
// Tagged push FIFO: 64-bit words plus a weight/activation tag, subordinate to array loader.
// Latency: a word pushed at edge N is at the head after edge N; head is first-word-fall-through.
// Backpressure: rd_ready gates pops; pushes while full are dropped and set sticky overrun_err.
module ahb_push_buffer #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_push,
    input  logic              is_weight,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clear,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_is_weight,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overrun_err
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overrun_q, overrun_d;

    // Tag is stored alongside the word in the top bit of each entry.
    logic [DATA_W:0]  mem_q [DEPTH];
    logic [DATA_W:0]  head;

    logic push_ok;
    logic pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = wr_en_push && !full;
    assign pop_ok  = !empty && rd_ready;

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_valid     = !empty;
    assign rd_data      = empty ? '0 : head[DATA_W-1:0];
    assign rd_is_weight = empty ? 1'b0 : head[DATA_W];
    assign count        = wr_ptr_q - rd_ptr_q;
    assign overrun_err  = overrun_q;

    // Next-state for pointers and the sticky overrun flag; clear wins over everything else.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en_push && full) begin
            overrun_d = 1'b1;
        end
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            overrun_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage write; contents are deliberately not reset, a flushed entry is simply unreachable.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {is_weight, wdata};
        end
    end

endmodule

// File: tb/tb_ahb_push_buffer.sv
module tb_ahb_push_buffer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en_push;
    logic              is_weight;
    logic [DATA_W-1:0] wdata;
    logic              clear;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_is_weight;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overrun_err;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of {tag, word} plus the sticky error bit.
    logic [DATA_W:0] mq[$];
    bit              movr;

    ahb_push_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_push   (wr_en_push),
        .is_weight    (is_weight),
        .wdata        (wdata),
        .clear        (clear),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_is_weight (rd_is_weight),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model with pre-edge state, compare after the edge.
    task automatic step(input bit p, input bit t, input logic [63:0] d,
                        input bit rdy, input bit clr, input bit r);
        bit              fl;
        bit              em;
        logic [DATA_W:0] hd;
        wr_en_push = p;
        is_weight  = t;
        wdata      = d;
        rd_ready   = rdy;
        clear      = clr;
        rst        = r;
        @(posedge clk);
        if (r || clr) begin
            mq.delete();
            movr = 1'b0;
        end else begin
            fl = (mq.size() == DEPTH);
            em = (mq.size() == 0);
            if (p && fl) movr = 1'b1;
            if (rdy && !em) void'(mq.pop_front());
            if (p && !fl) mq.push_back({t, d});
        end
        #1;
        hd = (mq.size() == 0) ? '0 : mq[0];
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_valid", 64'(rd_valid), 64'(mq.size() != 0));
        chk("m_empty", 64'(empty), 64'(mq.size() == 0));
        chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
        chk("m_overrun", 64'(overrun_err), 64'(movr));
        chk("m_data", rd_data, hd[DATA_W-1:0]);
        chk("m_tag", 64'(rd_is_weight), 64'(hd[DATA_W]));
    endtask

    typedef struct {
        bit          p;
        bit          t;
        logic [63:0] d;
        bit          rdy;
        bit          clr;
        bit          r;
        int          e_cnt;
        bit          e_vld;
        logic [63:0] e_dat;
        bit          e_tag;
        bit          e_full;
        bit          e_ovr;
    } vec_t;

    vec_t vec[$];

    function automatic logic [63:0] dw(input int i);
        return 64'hD0D0_0000_0000_0000 + 64'(i);
    endfunction

    initial begin
        vec_t v;
        rst = 1'b1; wr_en_push = 1'b0; is_weight = 1'b0; wdata = '0;
        clear = 1'b0; rd_ready = 1'b0; movr = 1'b0;

        // Directed table: reset, single push, fill, overrun, push+pop when full, clear.
        vec.push_back('{0, 0, 64'h0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0});
        vec.push_back('{1, 1, 64'hA5A5_0000_0000_0001, 0, 0, 0, 1, 1, 64'hA5A5_0000_0000_0001, 1, 0, 0});
        vec.push_back('{0, 0, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0, 0, 0});
        for (int i = 0; i < 8; i++) begin
            v = '{1, i[0], dw(i), 0, 0, 0, i + 1, 1, dw(0), 0, (i == 7), 0};
            vec.push_back(v);
        end
        vec.push_back('{1, 0, 64'hD0D0_0000_0000_0008, 0, 0, 0, 8, 1, 64'hD0D0_0000_0000_0000, 0, 1, 1});
        vec.push_back('{1, 1, 64'hD0D0_0000_0000_0009, 1, 0, 0, 7, 1, 64'hD0D0_0000_0000_0001, 1, 0, 1});
        vec.push_back('{0, 0, 64'h0, 0, 0, 0, 7, 1, 64'hD0D0_0000_0000_0001, 1, 0, 1});
        vec.push_back('{0, 0, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0, 0, 0});

        @(negedge clk);
        foreach (vec[k]) begin
            step(vec[k].p, vec[k].t, vec[k].d, vec[k].rdy, vec[k].clr, vec[k].r);
            chk($sformatf("v%0d_count", k), 64'(count), 64'(vec[k].e_cnt));
            chk($sformatf("v%0d_valid", k), 64'(rd_valid), 64'(vec[k].e_vld));
            chk($sformatf("v%0d_data", k), rd_data, vec[k].e_dat);
            chk($sformatf("v%0d_tag", k), 64'(rd_is_weight), 64'(vec[k].e_tag));
            chk($sformatf("v%0d_full", k), 64'(full), 64'(vec[k].e_full));
            chk($sformatf("v%0d_ovr", k), 64'(overrun_err), 64'(vec[k].e_ovr));
        end

        // Fill, overrun, then drain in order.
        for (int i = 0; i < 9; i++) step(1, i[0], dw(16 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", rd_data, dw(16 + i));
            step(0, 0, 0, 1, 0, 0);
        end
        chk("drain_empty", 64'(empty), 64'd1);
        step(0, 0, 0, 0, 1, 0);

        // Streaming push+pop with alternating tags; pointers wrap more than twice.
        step(1, 0, dw(100), 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            chk("stream_head", rd_data, dw(100 + i - 1));
            step(1, i[0], dw(100 + i), 1, 0, 0);
            chk("stream_count", 64'(count), 64'd1);
        end
        step(0, 0, 0, 1, 0, 0);

        // Head stays stable under backpressure; rd_ready while empty does nothing.
        step(1, 1, 64'hCAFE_F00D_1234_5678, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("hold_data", rd_data, 64'hCAFE_F00D_1234_5678);
            chk("hold_tag", 64'(rd_is_weight), 64'd1);
        end
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 0);
            chk("empty_pop_count", 64'(count), 64'd0);
        end

        // Reset mid-burst together with a push, after an overrun has been flagged.
        for (int i = 0; i < 9; i++) step(1, 0, dw(200 + i), 0, 0, 0);
        step(1, 1, dw(300), 1, 0, 1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ovr", 64'(overrun_err), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);

        // Clear colliding with push, pop and overrun in the same cycle.
        for (int i = 0; i < 8; i++) step(1, 1, dw(400 + i), 0, 0, 0);
        step(1, 0, dw(500), 1, 1, 0);
        chk("clr_prio_count", 64'(count), 64'd0);
        chk("clr_prio_ovr", 64'(overrun_err), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 1),
                 {$urandom, $urandom}, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
